// File: rtl/text_buffer_arbiter.sv
// text_buffer_arbiter: owns the 64-byte (4 rows x 16 cols) character buffer.
// It shares the single write port between an addressed writer (A) and a
// streaming cursor writer (B), and runs the full-screen clear sequence.
//
// Handshake: a transfer happens on a rising edge when valid && ready are both
// high. Ready is combinational from valid, state, clear_i and last grant.
// Ready never asserts without valid. At most one requester is granted per cycle.
module text_buffer_arbiter #(
    parameter logic [7:0] CLEAR_CHAR = 8'd32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] char_address_i,
    output logic [7:0] char_data_o,
    input  logic       clear_i,
    output logic       busy_o,
    input  logic       a_valid_i,
    output logic       a_ready_o,
    input  logic [5:0] a_addr_i,
    input  logic [7:0] a_data_i,
    input  logic       b_valid_i,
    output logic       b_ready_o,
    input  logic [7:0] b_data_i,
    input  logic       cursor_set_i,
    input  logic [5:0] cursor_i,
    output logic [5:0] cursor_o
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    localparam logic [7:0] NEWLINE = 8'h0A;
    localparam logic       GRANT_A = 1'b0;
    localparam logic       GRANT_B = 1'b1;

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [5:0] cursor_q, cursor_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] mem_q [64];

    logic       a_ready, b_ready;
    logic       we;
    logic [5:0] waddr;
    logic [7:0] wdata;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_CLEAR;
        else       state_q <= state_d;
    end

    // Next-state logic: a clear request always (re)enters CLEAR
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (clear_i)              state_d = ST_CLEAR;
                else if (idx_q == 6'd63)  state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (clear_i) state_d = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Output logic: round-robin grants and write-port mux
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        we      = 1'b0;
        waddr   = idx_q;
        wdata   = CLEAR_CHAR;
        case (state_q)
            ST_CLEAR: begin
                we = 1'b1;
            end
            ST_IDLE: begin
                if (!clear_i) begin
                    if (a_valid_i && b_valid_i) begin
                        a_ready = (last_grant_q == GRANT_B);
                        b_ready = (last_grant_q == GRANT_A);
                    end else begin
                        a_ready = a_valid_i;
                        b_ready = b_valid_i;
                    end
                end
                if (a_ready) begin
                    we    = 1'b1;
                    waddr = a_addr_i;
                    wdata = a_data_i;
                end else if (b_ready && (b_data_i != NEWLINE)) begin
                    we    = 1'b1;
                    waddr = cursor_q;
                    wdata = b_data_i;
                end
            end
            default: ;
        endcase
    end

    // Datapath next values: clear index, stream cursor, last grant
    always_comb begin
        idx_d        = 6'd0;
        cursor_d     = cursor_q;
        last_grant_d = last_grant_q;
        if ((state_q == ST_CLEAR) && !clear_i) idx_d = idx_q + 6'd1;
        if (a_ready) last_grant_d = GRANT_A;
        if (b_ready) begin
            last_grant_d = GRANT_B;
            if (b_data_i == NEWLINE) cursor_d = {cursor_q[5:4] + 2'd1, 4'd0};
            else                     cursor_d = cursor_q + 6'd1;
        end
        // A load overrides the stream advance; the B write above used the old cursor.
        if ((state_q == ST_IDLE) && cursor_set_i) cursor_d = cursor_i;
        if (clear_i) cursor_d = 6'd0;
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q        <= 6'd0;
            cursor_q     <= 6'd0;
            last_grant_q <= GRANT_B;
        end else begin
            idx_q        <= idx_d;
            cursor_q     <= cursor_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Character array write port; suppressed while reset is held
    always_ff @(posedge clk_i) begin
        if (!rst_i && we) mem_q[waddr] <= wdata;
    end

    assign char_data_o = mem_q[char_address_i];
    assign busy_o      = (state_q == ST_CLEAR);
    assign a_ready_o   = a_ready;
    assign b_ready_o   = b_ready;
    assign cursor_o    = cursor_q;

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Testbench for text_buffer_arbiter: table-driven arbitration vectors plus
// hand-written sequences for clear, stream wrap, newline and cursor load.
module tb_text_buffer_arbiter;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] char_address_i = '0;
    logic [7:0] char_data_o;
    logic       clear_i = 1'b0;
    logic       busy_o;
    logic       a_valid_i = 1'b0;
    logic       a_ready_o;
    logic [5:0] a_addr_i = '0;
    logic [7:0] a_data_i = '0;
    logic       b_valid_i = 1'b0;
    logic       b_ready_o;
    logic [7:0] b_data_i = '0;
    logic       cursor_set_i = 1'b0;
    logic [5:0] cursor_i = '0;
    logic [5:0] cursor_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Scoreboard of expected cell contents: {addr[13:8], byte[7:0]}
    logic [13:0] exp_q [$];

    typedef struct {
        logic       a_v;
        logic       b_v;
        logic [5:0] a_addr;
        logic [7:0] a_data;
        logic [7:0] b_data;
        logic       exp_ar;
        logic       exp_br;
        logic [5:0] exp_cur;
    } vec_t;

    vec_t vecs [11];

    text_buffer_arbiter #(.CLEAR_CHAR(8'd32)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .char_address_i (char_address_i),
        .char_data_o    (char_data_o),
        .clear_i        (clear_i),
        .busy_o         (busy_o),
        .a_valid_i      (a_valid_i),
        .a_ready_o      (a_ready_o),
        .a_addr_i       (a_addr_i),
        .a_data_i       (a_data_i),
        .b_valid_i      (b_valid_i),
        .b_ready_o      (b_ready_o),
        .b_data_i       (b_data_i),
        .cursor_set_i   (cursor_set_i),
        .cursor_i       (cursor_i),
        .cursor_o       (cursor_o)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic av, input logic bv, input logic [5:0] aa,
                                input logic [7:0] ad, input logic [7:0] bd,
                                input logic ear, input logic ebr, input logic [5:0] ec);
        vec_t v;
        v.a_v = av; v.b_v = bv; v.a_addr = aa; v.a_data = ad; v.b_data = bd;
        v.exp_ar = ear; v.exp_br = ebr; v.exp_cur = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle of inputs at the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic av, input logic bv, input logic [5:0] aa,
                         input logic [7:0] ad, input logic [7:0] bd,
                         input logic cs, input logic [5:0] ci, input logic clr);
        @(negedge clk);
        a_valid_i = av; b_valid_i = bv; a_addr_i = aa; a_data_i = ad;
        b_data_i = bd; cursor_set_i = cs; cursor_i = ci; clear_i = clr;
        #1;
    endtask

    task automatic quiet();
        drive(1'b0, 1'b0, 6'd0, 8'h00, 8'h00, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic expect_cell(input logic [5:0] addr, input logic [7:0] val);
        exp_q.push_back({addr, val});
    endtask

    // Pop every expected cell and compare against the combinational read port.
    task automatic drain();
        logic [13:0] e;
        quiet();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            char_address_i = e[13:8];
            #1;
            chk($sformatf("cell[%0d]", e[13:8]), {24'd0, char_data_o}, {24'd0, e[7:0]});
        end
    endtask

    // Let the registered outputs update after the edge that follows a drive.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_cnt;
        int viol;
        vec_t v;

        // ---------------- reset and power-on clear ----------------
        a_valid_i = 1'b1;
        a_addr_i  = 6'd0;
        a_data_i  = 8'h20;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset busy", {31'd0, busy_o}, 32'd1);
        chk("reset a_ready", {31'd0, a_ready_o}, 32'd0);
        chk("reset b_ready", {31'd0, b_ready_o}, 32'd0);
        chk("reset cursor", {26'd0, cursor_o}, 32'd0);
        rst_i = 1'b0;
        busy_cnt = 0;
        viol = 0;
        for (int n = 0; n < 200; n++) begin
            if (busy_o) begin
                busy_cnt++;
                if (a_ready_o || b_ready_o) viol++;
            end else begin
                chk("first ready after reset clear", {31'd0, a_ready_o}, 32'd1);
                a_valid_i = 1'b0;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("reset clear busy cycles", busy_cnt, 32'd64);
        chk("ready during reset clear", viol, 32'd0);
        for (int i = 0; i < 64; i++) expect_cell(i[5:0], 8'h20);
        drain();

        // ---------------- contention / fairness table ----------------
        vecs[0]  = mk(1'b1, 1'b1, 6'd5,  8'h41, 8'h42, 1'b1, 1'b0, 6'd0);
        vecs[1]  = mk(1'b0, 1'b1, 6'd5,  8'h41, 8'h42, 1'b0, 1'b1, 6'd1);
        vecs[2]  = mk(1'b0, 1'b1, 6'd5,  8'h41, 8'h43, 1'b0, 1'b1, 6'd2);
        vecs[3]  = mk(1'b1, 1'b1, 6'd10, 8'h61, 8'h44, 1'b1, 1'b0, 6'd2);
        vecs[4]  = mk(1'b1, 1'b1, 6'd10, 8'h61, 8'h44, 1'b0, 1'b1, 6'd3);
        vecs[5]  = mk(1'b1, 1'b1, 6'd11, 8'h62, 8'h45, 1'b1, 1'b0, 6'd3);
        vecs[6]  = mk(1'b1, 1'b1, 6'd11, 8'h62, 8'h45, 1'b0, 1'b1, 6'd4);
        vecs[7]  = mk(1'b0, 1'b0, 6'd0,  8'h00, 8'h00, 1'b0, 1'b0, 6'd4);
        vecs[8]  = mk(1'b1, 1'b0, 6'd12, 8'h63, 8'h00, 1'b1, 1'b0, 6'd4);
        vecs[9]  = mk(1'b1, 1'b1, 6'd13, 8'h64, 8'h46, 1'b0, 1'b1, 6'd5);
        vecs[10] = mk(1'b1, 1'b1, 6'd13, 8'h64, 8'h46, 1'b1, 1'b0, 6'd5);
        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            drive(v.a_v, v.b_v, v.a_addr, v.a_data, v.b_data, 1'b0, 6'd0, 1'b0);
            chk($sformatf("vec%0d a_ready", i), {31'd0, a_ready_o}, {31'd0, v.exp_ar});
            chk($sformatf("vec%0d b_ready", i), {31'd0, b_ready_o}, {31'd0, v.exp_br});
            settle();
            chk($sformatf("vec%0d cursor", i), {26'd0, cursor_o}, {26'd0, v.exp_cur});
        end
        expect_cell(6'd5, 8'h41);  expect_cell(6'd0, 8'h42);  expect_cell(6'd1, 8'h43);
        expect_cell(6'd10, 8'h61); expect_cell(6'd2, 8'h44);  expect_cell(6'd11, 8'h62);
        expect_cell(6'd3, 8'h45);  expect_cell(6'd12, 8'h63); expect_cell(6'd4, 8'h46);
        expect_cell(6'd13, 8'h64); expect_cell(6'd6, 8'h20);
        drain();

        // ---------------- stream wrap ----------------
        drive(1'b0, 1'b0, 6'd0, 8'h00, 8'h00, 1'b1, 6'd62, 1'b0);
        settle();
        chk("cursor load 62", {26'd0, cursor_o}, 32'd62);
        drive(1'b0, 1'b1, 6'd0, 8'h00, 8'h58, 1'b0, 6'd0, 1'b0);
        chk("wrap b_ready", {31'd0, b_ready_o}, 32'd1);
        settle();
        chk("wrap cursor 63", {26'd0, cursor_o}, 32'd63);
        drive(1'b0, 1'b1, 6'd0, 8'h00, 8'h59, 1'b0, 6'd0, 1'b0);
        settle();
        chk("wrap cursor 0", {26'd0, cursor_o}, 32'd0);
        drive(1'b0, 1'b1, 6'd0, 8'h00, 8'h5A, 1'b0, 6'd0, 1'b0);
        settle();
        chk("wrap cursor 1", {26'd0, cursor_o}, 32'd1);
        expect_cell(6'd62, 8'h58); expect_cell(6'd63, 8'h59); expect_cell(6'd0, 8'h5A);
        drain();

        // ---------------- newline ----------------
        drive(1'b0, 1'b0, 6'd0, 8'h00, 8'h00, 1'b1, 6'd19, 1'b0);
        settle();
        drive(1'b0, 1'b1, 6'd0, 8'h00, 8'h0A, 1'b0, 6'd0, 1'b0);
        chk("newline b_ready", {31'd0, b_ready_o}, 32'd1);
        settle();
        chk("newline from 19", {26'd0, cursor_o}, 32'd32);
        drive(1'b0, 1'b0, 6'd0, 8'h00, 8'h00, 1'b1, 6'd53, 1'b0);
        settle();
        drive(1'b0, 1'b1, 6'd0, 8'h00, 8'h0A, 1'b0, 6'd0, 1'b0);
        settle();
        chk("newline from 53", {26'd0, cursor_o}, 32'd0);
        expect_cell(6'd19, 8'h20); expect_cell(6'd32, 8'h20); expect_cell(6'd53, 8'h20);
        drain();

        // ---------------- same-cycle cursor load and B write ----------------
        drive(1'b0, 1'b0, 6'd0, 8'h00, 8'h00, 1'b1, 6'd3, 1'b0);
        settle();
        drive(1'b0, 1'b1, 6'd0, 8'h00, 8'h4B, 1'b1, 6'd10, 1'b0);
        chk("load+write b_ready", {31'd0, b_ready_o}, 32'd1);
        settle();
        chk("load overrides advance", {26'd0, cursor_o}, 32'd10);
        expect_cell(6'd3, 8'h4B); expect_cell(6'd10, 8'h61);
        drain();

        // ---------------- clear during traffic, restarted mid-clear ----------------
        busy_cnt = 0;
        viol = 0;
        for (int n = 0; n < 200; n++) begin
            drive(1'b1, 1'b1, 6'd7, 8'h77, 8'h78, 1'b0, 6'd0, (n == 0) || (n == 31));
            if (n == 0) begin
                chk("clear cycle a_ready", {31'd0, a_ready_o}, 32'd0);
                chk("clear cycle b_ready", {31'd0, b_ready_o}, 32'd0);
            end else if (busy_o) begin
                busy_cnt++;
                if (a_ready_o || b_ready_o) viol++;
                if (n == 1) chk("cursor after clear", {26'd0, cursor_o}, 32'd0);
            end else begin
                chk("first grant after clear is A", {31'd0, a_ready_o}, 32'd1);
                a_valid_i = 1'b0;
                b_valid_i = 1'b0;
                break;
            end
            @(posedge clk);
        end
        chk("restarted clear busy cycles", busy_cnt, 32'd95);
        chk("ready during clear", viol, 32'd0);
        expect_cell(6'd3, 8'h20);  expect_cell(6'd5, 8'h20);
        expect_cell(6'd62, 8'h20); expect_cell(6'd7, 8'h20);
        drain();
        chk("cursor idle after clear", {26'd0, cursor_o}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/text_buffer_arbiter.md
# text_buffer_arbiter

Owns the 64-byte character buffer, a 4 rows × 16 columns screen, that the text engine reads while it renders pixels. It shares the buffer's single write port between two requesters and runs a full-screen clear sequence:
- Requester A writes to an explicit address, e.g. value/status fields.
- Requester B is a streaming writer with an internal cursor, e.g. a UART text console.

It sits between the application-side text producers and the text engine's `char_address`/`char_data` port.

## Interface
- `CLEAR_CHAR`, default 8'd32: byte written to every cell during a clear.
- `clk_i` input 1: system clock; all state changes on its rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `char_address_i` input 6: read address from the text engine, {row[1:0], col[3:0]}.
- `char_data_o` output 8: buffer byte at `char_address_i`, combinational.
- `clear_i` input 1: single-cycle clear request.
- `busy_o` output 1: high while a clear is in progress.
- `a_valid_i` input 1: requester A write request.
- `a_ready_o` output 1: requester A granted this cycle.
- `a_addr_i` input 6: requester A target cell.
- `a_data_i` input 8: requester A byte.
- `b_valid_i` input 1: requester B stream request.
- `b_ready_o` output 1: requester B granted this cycle.
- `b_data_i` input 8: requester B byte; 8'h0A means newline.
- `cursor_set_i` input 1: load the stream cursor.
- `cursor_i` input 6: value to load.
- `cursor_o` output 6: current stream cursor.

## Operation
- **Storage:** 64 × 8 array, one write port, one combinational read port for the engine.
- **States:**
  - CLEAR: index counter `idx` (6 bits) writes `CLEAR_CHAR` to `idx` each cycle.
  - IDLE: arbitrated writes.
- **Reset:**
  - State = CLEAR, `idx` = 0, cursor = 0, `last_grant` = B.
  - While `rst_i` is high, no array writes occur.
- **CLEAR state:**
  - Each cycle writes `CLEAR_CHAR` to `idx`, then `idx` += 1.
  - On the cycle `idx` = 63 the state moves to IDLE.
  - `clear_i` during CLEAR restarts the sequence: `idx` = 0 next cycle, and cell 0 is written again.
  - Both readies are forced low.
  - `cursor_set_i` is ignored.
- **IDLE, `clear_i` high:**
  - No transfer occurs; both readies are low that cycle.
  - Next state = CLEAR, `idx` = 0, cursor = 0.
- **IDLE, `clear_i` low:** at most one transfer per cycle (a transfer is `valid && ready`).
  - Only A valid: `a_ready_o` = 1.
  - Only B valid: `b_ready_o` = 1.
  - Both valid: grant the requester that is not `last_grant` (round-robin).
  - `last_grant` updates only on a transfer.
  - Readies are combinational from `valid`, state, `clear_i` and `last_grant`; there is no ready without valid.
- **A transfer:** `mem[a_addr_i]` ← `a_data_i`. The cursor is unaffected.
- **B transfer, `b_data_i` ≠ 8'h0A:**
  - `mem[cursor]` ← `b_data_i`.
  - Cursor ← cursor + 1, wrapping 63→0.
- **B transfer, `b_data_i` = 8'h0A:**
  - No array write.
  - Cursor ← {cursor[5:4]+1, 4'd0}; row 3 wraps to row 0.
- **`cursor_set_i` in IDLE:**
  - Cursor ← `cursor_i`, overriding any B-transfer update in the same cycle.
  - A B write in that same cycle still uses the old cursor.
- **Byte handling:** bytes are stored unmodified; substituting non-printable characters is the text engine's job.
- **Priority, highest first:** `rst_i` > `clear_i` > `cursor_set_i` (cursor only) > arbitrated transfer.

## Timing
- **Reset values:**
  - `busy_o` = 1.
  - `a_ready_o` = 0, `b_ready_o` = 0.
  - `cursor_o` = 0.
  - `char_data_o` is undefined until the first clear completes.
- **Clear duration:**
  - Exactly 64 cycles from the first cycle after `rst_i` falls, or from the cycle after `clear_i` is accepted.
  - `busy_o` = (state == CLEAR), registered.
  - A ready can first assert on cycle 65.
- **Write latency:** a write accepted at edge N is visible on `char_data_o` for a matching address from edge N onward (the same clock edge).
- **Ready timing:** combinational in the same cycle as `valid`; zero-bubble back-to-back transfers.
- **Fairness:** with both requesters continuously valid, grants alternate A, B, A, B…
  - Neither requester waits more than one cycle.
- **Cursor update:** `cursor_o` is registered and reflects a transfer or load on the following cycle.
- **Mid-operation reset:** `rst_i` during CLEAR or IDLE restarts CLEAR at `idx` 0 with cursor 0.
  - Array contents are not guaranteed until that clear finishes.

## Test plan
- **Reset clear:** pulse `rst_i` for 2 cycles, then release.
  - `busy_o` stays 1 for 64 cycles.
  - All 64 addresses read 8'h20 afterwards.
  - `a_ready_o` stays 0 while `a_valid_i` is held high throughout the clear.
- **Contention:** A holds addr 5 / 8'h41 and B streams 8'h42, 8'h43, both valid from cycle 0.
  - Grants go A, B, then B (A has dropped).
  - Result: cell 5 = 8'h41, cell 0 = 8'h42, cell 1 = 8'h43, `cursor_o` = 2.
- **Stream wrap:** `cursor_set_i` with 6'd62, then B sends 8'h58, 8'h59, 8'h5A.
  - Cells 62, 63, 0 hold those bytes; `cursor_o` = 1.
- **Newline:** cursor = 6'd19, B sends 8'h0A.
  - `cursor_o` = 32 and no cell changes.
  - A further newline from cursor 53 gives 0.
- **Clear during traffic:** `clear_i` pulses while both requesters are valid.
  - Both readies are 0 that cycle and for the next 64 cycles.
  - `cursor_o` = 0.
  - A second `clear_i` at clear cycle 30 extends `busy_o` to 64 cycles after that second pulse.
- **Same-cycle cursor load and B write:** `cursor_set_i` (6'd10) coincides with a B write of 8'h4B at cursor 3.
  - Cell 3 = 8'h4B, `cursor_o` = 10.
